// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB full-speed transmit path.
//   tx_packet_t  - request codes presented on tx_packet
//   tx_state_t   - transmit FSM states
//   PID_*        - 4-bit packet identifiers
//   SYNC_BYTE    - sync pattern, sent LSB-first
//   CRC16_*      - data CRC polynomial and init value
//   LINE_*       - {dp, dm} line encodings
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_INVALID = 3'd0,
    PKT_DATA0   = 3'd1,
    PKT_DATA1   = 3'd2,
    PKT_ACK     = 3'd3,
    PKT_NAK     = 3'd4,
    PKT_STALL   = 3'd5
  } tx_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP, ST_EOPJ
  } tx_state_t;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;  // x^16 + x^15 + x^2 + 1
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic packet_valid(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd5);
  endfunction

  // Full PID byte: check nibble in the upper half.
  function automatic logic [7:0] pid_byte(input tx_packet_t pkt);
    logic [3:0] pid;
    case (pkt)
      PKT_DATA0: pid = PID_DATA0;
      PKT_DATA1: pid = PID_DATA1;
      PKT_ACK:   pid = PID_ACK;
      PKT_NAK:   pid = PID_NAK;
      PKT_STALL: pid = PID_STALL;
      default:   pid = 4'h0;
    endcase
    return {~pid, pid};
  endfunction

  function automatic logic [15:0] reverse16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Payload is shifted in LSB-first, so the register runs in reflected form.
  localparam logic [15:0] CRC16_POLY_REFL = reverse16(CRC16_POLY);

endpackage

// File: rtl/usb_tx_crc16.sv
// usb_tx_crc16: serial CRC16 over payload bits, LSB-first (reflected form).
//   clk, n_rst  - clock and synchronous active-high reset
//   clear       - reload the init value (start of packet)
//   shift_en    - absorb bit_in this cycle
//   bit_in      - payload bit
//   crc_out     - inverted remainder; bit 0 is transmitted first
module usb_tx_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_reg;

  always_ff @(posedge clk) begin
    if (n_rst || clear) begin
      crc_reg <= CRC16_INIT;
    end else if (shift_en) begin
      crc_reg <= (crc_reg >> 1) ^ ((crc_reg[0] ^ bit_in) ? CRC16_POLY_REFL : 16'h0000);
    end
  end

  assign crc_out = ~crc_reg;

endmodule

// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter (SYNC, PID, payload, CRC16,
// bit stuffing, NRZI, EOP).
//   clk, n_rst          - clock and synchronous active-high reset
//   tx_start/tx_packet  - request pulse and packet type
//   tx_packet_data      - FIFO head byte (first-word-fall-through)
//   buffer_occupancy    - FIFO byte count
//   get_tx_packet_data  - one-cycle FIFO pop strobe
//   tx_transfer_active  - packet in progress (through the idle J bit)
//   tx_error            - last request had an invalid type
//   dp, dm              - USB line
module usb_tx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic [6:0] buffer_occupancy,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       dp,
  output logic       dm
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [TW-1:0] TIMER_TOP = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTES_MAX = BW'(MAX_BYTES);

  tx_state_t   state_reg, state_next;
  tx_packet_t  pkt_reg, pkt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  ones_reg, ones_next;
  logic [1:0]  line_reg, line_next;
  logic [BW-1:0] byte_cnt_reg, byte_cnt_next;
  logic        error_reg, error_next;
  logic        active_reg, active_next;
  logic        get_reg, get_next;

  logic        crc_clear, crc_shift, crc_bit;
  logic [15:0] crc_out;
  logic [7:0]  pid_bits;
  logic [3:0]  idx_next;
  logic        boundary, launch, launch_bit, byte_end;

  assign pid_bits = pid_byte(pkt_reg);
  assign idx_next = bit_cnt_reg + 4'd1;
  assign boundary = (timer_reg == '0);

  usb_tx_crc16 u_crc (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .bit_in   (crc_bit),
    .crc_out  (crc_out)
  );

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_reg    <= ST_IDLE;
      pkt_reg      <= PKT_ACK;
      timer_reg    <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      ones_reg     <= '0;
      line_reg     <= LINE_J;
      byte_cnt_reg <= '0;
      error_reg    <= 1'b0;
      active_reg   <= 1'b0;
      get_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pkt_reg      <= pkt_next;
      timer_reg    <= timer_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      ones_reg     <= ones_next;
      line_reg     <= line_next;
      byte_cnt_reg <= byte_cnt_next;
      error_reg    <= error_next;
      active_reg   <= active_next;
      get_reg      <= get_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pkt_next      = pkt_reg;
    timer_next    = timer_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ones_next     = ones_reg;
    line_next     = line_reg;
    byte_cnt_next = byte_cnt_reg;
    error_next    = error_reg;
    active_next   = active_reg;
    get_next      = 1'b0;
    crc_clear     = 1'b0;
    crc_shift     = 1'b0;
    crc_bit       = 1'b0;
    launch        = 1'b0;
    launch_bit    = 1'b0;
    byte_end      = 1'b0;

    if (state_reg != ST_IDLE) begin
      timer_next = boundary ? TIMER_TOP : timer_reg - 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (tx_start) begin
          if (packet_valid(tx_packet)) begin
            pkt_next      = tx_packet_t'(tx_packet);
            error_next    = 1'b0;
            active_next   = 1'b1;
            state_next    = ST_SYNC;
            timer_next    = TIMER_TOP;
            bit_cnt_next  = '0;
            byte_cnt_next = '0;
            crc_clear     = 1'b1;
            // NRZI reference is J here; first sync bit goes straight out.
            ones_next     = SYNC_BYTE[0] ? 3'd1 : 3'd0;
            line_next     = SYNC_BYTE[0] ? LINE_J : LINE_K;
          end else begin
            error_next = 1'b1;
          end
        end
      end

      ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
        if (boundary) begin
          if (ones_reg == 3'd6) begin
            // Stuff bit: forced transition, field position untouched.
            ones_next = '0;
            line_next = ~line_reg;
          end else begin
            case (state_reg)
              ST_SYNC: begin
                launch = 1'b1;
                if (bit_cnt_reg == 4'd7) begin
                  state_next   = ST_PID;
                  bit_cnt_next = '0;
                  launch_bit   = pid_bits[0];
                end else begin
                  bit_cnt_next = idx_next;
                  launch_bit   = SYNC_BYTE[idx_next[2:0]];
                end
              end
              ST_PID: begin
                if (bit_cnt_reg != 4'd7) begin
                  launch       = 1'b1;
                  bit_cnt_next = idx_next;
                  launch_bit   = pid_bits[idx_next[2:0]];
                end else if (pkt_reg == PKT_DATA0 || pkt_reg == PKT_DATA1) begin
                  byte_end = 1'b1;
                end else begin
                  state_next   = ST_EOP;
                  bit_cnt_next = '0;
                  line_next    = LINE_SE0;
                end
              end
              ST_DATA: begin
                if (bit_cnt_reg != 4'd7) begin
                  launch       = 1'b1;
                  bit_cnt_next = idx_next;
                  launch_bit   = shift_reg[idx_next[2:0]];
                  crc_shift    = 1'b1;
                  crc_bit      = launch_bit;
                end else begin
                  byte_end = 1'b1;
                end
              end
              default: begin  // ST_CRC
                if (bit_cnt_reg != 4'd15) begin
                  launch       = 1'b1;
                  bit_cnt_next = idx_next;
                  launch_bit   = crc_out[idx_next];
                end else begin
                  state_next   = ST_EOP;
                  bit_cnt_next = '0;
                  line_next    = LINE_SE0;
                end
              end
            endcase
          end
        end
      end

      ST_EOP: begin
        if (boundary) begin
          if (bit_cnt_reg == 4'd1) begin
            state_next   = ST_EOPJ;
            bit_cnt_next = '0;
            line_next    = LINE_J;
          end else begin
            bit_cnt_next = idx_next;
          end
        end
      end

      ST_EOPJ: begin
        if (boundary) begin
          state_next  = ST_IDLE;
          active_next = 1'b0;
          timer_next  = '0;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Byte boundary in the payload: fetch another byte or close with CRC.
    // Occupancy is looked at only here.
    if (byte_end) begin
      launch       = 1'b1;
      bit_cnt_next = '0;
      if (buffer_occupancy != 7'd0 && byte_cnt_reg < BYTES_MAX) begin
        state_next    = ST_DATA;
        shift_next    = tx_packet_data;
        get_next      = 1'b1;
        byte_cnt_next = byte_cnt_reg + 1'b1;
        launch_bit    = tx_packet_data[0];
        crc_shift     = 1'b1;
        crc_bit       = tx_packet_data[0];
      end else begin
        state_next = ST_CRC;
        launch_bit = crc_out[0];
      end
    end

    // NRZI: 1 holds the line, 0 toggles it.
    if (launch) begin
      if (launch_bit) begin
        ones_next = ones_reg + 3'd1;
      end else begin
        ones_next = '0;
        line_next = ~line_reg;
      end
    end
  end

  assign dp                 = line_reg[1];
  assign dm                 = line_reg[0];
  assign get_tx_packet_data = get_reg;
  assign tx_transfer_active = active_reg;
  assign tx_error           = error_reg;

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed bench for usb_tx. Captures the line cycle by cycle,
// NRZI-decodes and destuffs it, and compares against hand-derived values.
module tb_usb_tx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       get_tx_packet_data;
  logic       tx_transfer_active;
  logic       tx_error;
  logic       dp;
  logic       dm;

  always #5 clk = ~clk;

  usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .dp                 (dp),
    .dm                 (dm)
  );

  // First-word-fall-through FIFO model
  logic [7:0] fifo_mem [0:15];
  int         fifo_cnt;
  int         fifo_rd;
  logic       fifo_reset;

  assign tx_packet_data   = fifo_mem[fifo_rd[3:0]];
  assign buffer_occupancy = (fifo_rd < fifo_cnt) ? 7'(fifo_cnt - fifo_rd) : 7'd0;

  always @(posedge clk) begin
    if (fifo_reset) fifo_rd <= 0;
    else if (get_tx_packet_data) fifo_rd <= fifo_rd + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [1:0] trace [$];
  logic [7:0] dec_bytes [$];
  logic [7:0] payload_q [$];
  int   gets, ncyc, stuff_cnt, stuff_bad, align_bad;
  logic eop_ok;
  string line_str;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  task automatic load_fifo(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    fifo_mem[0] = b0;
    fifo_mem[1] = b1;
    fifo_mem[2] = b2;
    fifo_cnt    = n;
    payload_q.delete();
    if (n > 0) payload_q.push_back(b0);
    if (n > 1) payload_q.push_back(b1);
    if (n > 2) payload_q.push_back(b2);
    fifo_reset = 1'b1;
    @(posedge clk);
    #1 fifo_reset = 1'b0;
  endtask

  // Request a packet and record {dp,dm} once per cycle while active.
  task automatic run_packet(input logic [2:0] ptype, input int inject_at,
                            input logic [2:0] inject_type, input int rst_at);
    trace.delete();
    gets = 0;
    ncyc = 0;
    @(negedge clk);
    tx_start  = 1'b1;
    tx_packet = ptype;
    @(negedge clk);
    tx_start = 1'b0;
    while (tx_transfer_active === 1'b1 && ncyc < 2000) begin
      trace.push_back({dp, dm});
      if (get_tx_packet_data === 1'b1) gets++;
      if (ncyc == inject_at) begin
        tx_start  = 1'b1;
        tx_packet = inject_type;
      end else begin
        tx_start = 1'b0;
      end
      n_rst = (ncyc == rst_at);
      ncyc++;
      @(negedge clk);
    end
    tx_start = 1'b0;
    n_rst    = 1'b0;
    check("active_ends", {31'd0, tx_transfer_active}, 32'd0);
  endtask

  function automatic string sym_str(input logic [1:0] s);
    case (s)
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "S";
      default: return "X";
    endcase
  endfunction

  task automatic decode();
    int nbits;
    int run;
    logic [1:0] prev;
    logic [1:0] s;
    logic b;
    logic [7:0] acc;
    int nacc;
    dec_bytes.delete();
    stuff_cnt = 0;
    stuff_bad = 0;
    align_bad = 0;
    line_str  = "";
    nbits = trace.size() / CPB;
    if (trace.size() % CPB != 0) align_bad++;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 1; c < CPB; c++)
        if (trace[i*CPB+c] !== trace[i*CPB]) align_bad++;
      line_str = {line_str, sym_str(trace[i*CPB])};
    end
    eop_ok = 1'b0;
    if (nbits >= 3)
      eop_ok = (trace[(nbits-3)*CPB] === 2'b00) && (trace[(nbits-2)*CPB] === 2'b00) &&
               (trace[(nbits-1)*CPB] === 2'b10);
    prev = 2'b10;
    run  = 0;
    acc  = 8'h00;
    nacc = 0;
    for (int i = 0; i < nbits - 3; i++) begin
      s = trace[i*CPB];
      b = (s === prev);
      prev = s;
      if (run == 6) begin
        stuff_cnt++;
        if (b) stuff_bad++;
        run = 0;
      end else begin
        run = b ? run + 1 : 0;
        acc = {b, acc[7:1]};
        nacc++;
        if (nacc == 8) begin
          dec_bytes.push_back(acc);
          nacc = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    if (i < dec_bytes.size()) return dec_bytes[i];
    return 8'hxx;
  endfunction

  // Non-reflected CRC16 over payload_q; returns the 16-bit field as sent
  // (field bit 0 first on the wire).
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    logic [15:0] r;
    logic fb;
    logic [7:0] d;
    c = 16'hFFFF;
    foreach (payload_q[k]) begin
      d = payload_q[k];
      for (int bi = 0; bi < 8; bi++) begin
        fb = d[bi] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
    return r;
  endfunction

  function automatic logic [15:0] crc_field(input int first);
    return {byte_at(first + 1), byte_at(first)};
  endfunction

  initial begin
    string ack_line;
    ack_line  = "KJKJKJKKJJKJJKKKSSJ";
    n_rst     = 1'b1;
    tx_start  = 1'b0;
    tx_packet = 3'd0;
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;
    fifo_cnt   = 0;
    fifo_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_dm", {31'd0, dm}, 32'd0);
    check("rst_active", {31'd0, tx_transfer_active}, 32'd0);
    check("rst_get", {31'd0, get_tx_packet_data}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    n_rst      = 1'b0;
    fifo_reset = 1'b0;

    // ACK handshake
    run_packet(3'd3, -1, 3'd0, -1);
    decode();
    check("ack_cycles", ncyc, 19 * CPB);
    check_str("ack_line", line_str, ack_line);
    check("ack_align", align_bad, 0);
    check("ack_gets", gets, 0);
    $display("ACK: %0d cycles, line %s", ncyc, line_str);

    // DATA0 zero-length
    load_fifo(0, 8'h00, 8'h00, 8'h00);
    run_packet(3'd1, -1, 3'd0, -1);
    decode();
    check("d0z_cycles", ncyc, 35 * CPB);
    check("d0z_nbytes", dec_bytes.size(), 4);
    check("d0z_sync", byte_at(0), 8'h80);
    check("d0z_pid", byte_at(1), 8'hC3);
    check("d0z_crc", crc_field(2), 16'h0000);
    check("d0z_eop", {31'd0, eop_ok}, 32'd1);
    check("d0z_gets", gets, 0);
    $display("DATA0 zero-length: %0d cycles, line %s", ncyc, line_str);

    // DATA1 FF 01: one stuff in payload, two in CRC (7E 7F)
    load_fifo(2, 8'hFF, 8'h01, 8'h00);
    run_packet(3'd2, -1, 3'd0, -1);
    decode();
    check("d1_cycles", ncyc, 54 * CPB);
    check("d1_stuffs", stuff_cnt, 3);
    check("d1_stuff_zero", stuff_bad, 0);
    check("d1_nbytes", dec_bytes.size(), 6);
    check("d1_pid", byte_at(1), 8'h4B);
    check("d1_b0", byte_at(2), 8'hFF);
    check("d1_b1", byte_at(3), 8'h01);
    check("d1_crc_model", crc_field(4), crc_model());
    check("d1_crc_hand", crc_field(4), 16'h7F7E);
    check("d1_gets", gets, 2);
    check("d1_eop", {31'd0, eop_ok}, 32'd1);
    check("d1_align", align_bad, 0);
    $display("DATA1 FF 01: %0d cycles, %0d stuff bits, line %s", ncyc, stuff_cnt, line_str);

    // Invalid types 0 and 7
    @(negedge clk);
    tx_start  = 1'b1;
    tx_packet = 3'd0;
    @(negedge clk);
    tx_start = 1'b0;
    check("inv0_error", {31'd0, tx_error}, 32'd1);
    check("inv0_active", {31'd0, tx_transfer_active}, 32'd0);
    repeat (10) @(negedge clk);
    check("inv0_line", {30'd0, dp, dm}, 32'd2);
    tx_start  = 1'b1;
    tx_packet = 3'd7;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (10) @(negedge clk);
    check("inv7_error", {31'd0, tx_error}, 32'd1);
    check("inv7_line", {30'd0, dp, dm}, 32'd2);
    $display("invalid requests: tx_error=%0b line=%0b%0b", tx_error, dp, dm);
    run_packet(3'd4, -1, 3'd0, -1);
    decode();
    check("nak_err_clear", {31'd0, tx_error}, 32'd0);
    check("nak_pid", byte_at(1), 8'h5A);
    check("nak_cycles", ncyc, 19 * CPB);
    $display("NAK after invalid: tx_error=%0b, %0d cycles", tx_error, ncyc);

    // tx_start (ACK) during payload is ignored
    load_fifo(2, 8'hA5, 8'h3C, 8'h00);
    run_packet(3'd1, 140, 3'd3, -1);
    decode();
    check("inj_pid", byte_at(1), 8'hC3);
    check("inj_b0", byte_at(2), 8'hA5);
    check("inj_b1", byte_at(3), 8'h3C);
    check("inj_crc", crc_field(4), crc_model());
    check("inj_gets", gets, 2);
    check("inj_error", {31'd0, tx_error}, 32'd0);
    $display("DATA0 with mid-payload tx_start: %0d bytes decoded", dec_bytes.size());

    // Reset at the edge that would fetch the third payload byte
    load_fifo(3, 8'h11, 8'h22, 8'h33);
    run_packet(3'd2, -1, 3'd0, 255);
    check("mrst_cycles", ncyc, 256);
    check("mrst_line", {30'd0, dp, dm}, 32'd2);
    check("mrst_active", {31'd0, tx_transfer_active}, 32'd0);
    check("mrst_get", {31'd0, get_tx_packet_data}, 32'd0);
    $display("reset mid-payload after %0d cycles: line=%0b%0b", ncyc, dp, dm);
    load_fifo(0, 8'h00, 8'h00, 8'h00);
    run_packet(3'd3, -1, 3'd0, -1);
    decode();
    check("post_ack_cycles", ncyc, 19 * CPB);
    check_str("post_ack_line", line_str, ack_line);
    $display("ACK after reset: %0d cycles, line %s", ncyc, line_str);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
